// File: rtl/lbus_pkg.sv
// Shared definitions for the local-bus master.
// Holds the transaction state encoding, the request size encodings and the
// active-low byte-enable patterns driven onto the register-file bus, plus
// two small helpers that decode a request's legality and write byte enables.
package lbus_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        STROBE,
        HOLD,
        RESP
    } lbus_state_t;

    localparam logic [1:0] SZ_BYTE    = 2'd0;
    localparam logic [1:0] SZ_HALF    = 2'd1;
    localparam logic [1:0] SZ_WORD    = 2'd2;
    localparam logic [1:0] SZ_ILLEGAL = 2'd3;

    // Byte enables are active low; bit 3 is the lowest byte lane, so a
    // right-justified byte pulls only bit 3 low.
    localparam logic [3:0] BE_WORD = 4'h0;
    localparam logic [3:0] BE_HALF = 4'h3;
    localparam logic [3:0] BE_BYTE = 4'h7;
    localparam logic [3:0] BE_NONE = 4'hF;

    // A request is rejected for the illegal size code or when the address
    // is not naturally aligned to the access size.
    function automatic logic req_is_bad(input logic [1:0] size, input logic [1:0] addr_lo);
        logic bad;
        bad = 1'b0;
        case (size)
            SZ_HALF: bad = addr_lo[0];
            SZ_WORD: bad = (addr_lo != 2'b00);
            SZ_BYTE: bad = 1'b0;
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

    function automatic logic [3:0] write_be(input logic [1:0] size);
        logic [3:0] be;
        be = BE_WORD;
        case (size)
            SZ_BYTE: be = BE_BYTE;
            SZ_HALF: be = BE_HALF;
            default: be = BE_WORD;
        endcase
        return be;
    endfunction

endpackage

// File: rtl/lbus_phase_ctr.sv
// Loadable 4-bit down-counter timing the SETUP, STROBE and HOLD phases.
// Ports:
//   clk, rst  : clock and asynchronous active-high reset
//   load      : load load_val this cycle (asserted on every state entry)
//   load_val  : cycles-1 for the phase being entered
//   count     : current remaining count
//   done      : count has reached zero, the current cycle is the last one
module lbus_phase_ctr (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [3:0] load_val,
    output logic [3:0] count,
    output logic       done
);

    // Count down to zero and park there until the next phase reloads it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= 4'd0;
        end else if (load) begin
            count <= load_val;
        end else if (count != 4'd0) begin
            count <= count - 4'd1;
        end
    end

    assign done = (count == 4'd0);

endmodule

// File: rtl/lbus_master.sv
// Local-bus master: turns a valid/ready request into one strobed
// register-file transaction (SETUP -> STROBE -> HOLD) and reports the
// result on a single-cycle response pulse. Illegal or misaligned requests
// answer immediately with resp_err and never touch the bus.
// Ports:
//   clk, rst                          : clock, asynchronous active-high reset
//   req_valid/req_ready               : request handshake (ready only in IDLE)
//   req_write/req_size/req_addr/req_wdata : request fields
//   resp_valid/resp_rdata/resp_err    : completion pulse, read data, error
//   busy                              : transaction in progress
//   bus_addr/bus_din/bus_dout         : register-file address and data
//   bus_ws_n/bus_rs_n/bus_be/bus_as   : strobes, active-low byte enables,
//                                       address strobe
// All outputs are registered.
module lbus_master
    import lbus_pkg::*;
#(
    parameter int ADDR_W     = 24,
    parameter int DATA_W     = 32,
    parameter int SETUP_CYC  = 1,
    parameter int STROBE_CYC = 2,
    parameter int HOLD_CYC   = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [1:0]        req_size,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err,
    output logic              busy,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_din,
    input  logic [DATA_W-1:0] bus_dout,
    output logic              bus_ws_n,
    output logic              bus_rs_n,
    output logic [3:0]        bus_be,
    output logic              bus_as
);

    // Phase lengths must fit the 4-bit phase counter and be non-zero.
    if (SETUP_CYC < 1 || SETUP_CYC > 15) begin : g_bad_setup
        $error("lbus_master: SETUP_CYC must be in 1..15");
    end
    if (STROBE_CYC < 1 || STROBE_CYC > 15) begin : g_bad_strobe
        $error("lbus_master: STROBE_CYC must be in 1..15");
    end
    if (HOLD_CYC < 1 || HOLD_CYC > 15) begin : g_bad_hold
        $error("lbus_master: HOLD_CYC must be in 1..15");
    end
    if (DATA_W != 32) begin : g_bad_data
        $error("lbus_master: DATA_W must be 32 (four byte lanes)");
    end

    lbus_state_t       state;
    lbus_state_t       state_next;
    logic              wr_q;
    logic              accept;
    logic              bad_req;
    logic              ctr_load;
    logic [3:0]        ctr_load_val;
    logic [3:0]        ctr_count;
    logic              ctr_done;
    logic              capture;
    logic [DATA_W-1:0] lane_din;

    assign accept  = (state == IDLE) && req_valid;
    assign bad_req = req_is_bad(req_size, req_addr[1:0]);
    // Read data is sampled once, at the end of the first HOLD cycle.
    assign capture = (state == HOLD) && !wr_q && (ctr_count == 4'(HOLD_CYC - 1));

    lbus_phase_ctr u_phase_ctr (
        .clk      (clk),
        .rst      (rst),
        .load     (ctr_load),
        .load_val (ctr_load_val),
        .count    (ctr_count),
        .done     (ctr_done)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state plus counter reload; the counter is reloaded whenever the
    // state changes, with the length of the phase being entered.
    always_comb begin
        state_next   = state;
        ctr_load     = 1'b0;
        ctr_load_val = 4'd0;
        case (state)
            IDLE:    if (req_valid) state_next = bad_req ? RESP : SETUP;
            SETUP:   if (ctr_done) state_next = STROBE;
            STROBE:  if (ctr_done) state_next = HOLD;
            HOLD:    if (ctr_done) state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (state_next != state) begin
            ctr_load = 1'b1;
            case (state_next)
                SETUP:   ctr_load_val = 4'(SETUP_CYC - 1);
                STROBE:  ctr_load_val = 4'(STROBE_CYC - 1);
                HOLD:    ctr_load_val = 4'(HOLD_CYC - 1);
                default: ctr_load_val = 4'd0;
            endcase
        end
    end

    // Write data is right-justified; lanes above the access size go to zero.
    always_comb begin
        lane_din = '0;
        case (req_size)
            SZ_BYTE: lane_din[7:0]  = req_wdata[7:0];
            SZ_HALF: lane_din[15:0] = req_wdata[15:0];
            default: lane_din       = req_wdata;
        endcase
    end

    // Output registers are decoded from the next state so each output
    // changes on the same edge as the state it belongs to.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q       <= 1'b0;
            req_ready  <= 1'b1;
            busy       <= 1'b0;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= '0;
            bus_as     <= 1'b0;
            bus_ws_n   <= 1'b1;
            bus_rs_n   <= 1'b1;
            bus_be     <= BE_NONE;
            bus_addr   <= '0;
            bus_din    <= '0;
        end else begin
            req_ready  <= (state_next == IDLE);
            busy       <= (state_next != IDLE);
            resp_valid <= (state_next == RESP);
            resp_err   <= accept && bad_req;
            bus_as     <= (state_next == SETUP) || (state_next == STROBE) ||
                          (state_next == HOLD);
            bus_ws_n   <= !((state_next == STROBE) && wr_q);
            bus_rs_n   <= !((state_next == STROBE) && !wr_q);
            if (accept) begin
                resp_rdata <= '0;
                if (!bad_req) begin
                    wr_q     <= req_write;
                    bus_addr <= req_addr;
                    bus_be   <= req_write ? write_be(req_size) : BE_NONE;
                    bus_din  <= lane_din;
                end
            end
            if (capture) begin
                resp_rdata <= bus_dout;
            end
            if (state_next == RESP) begin
                bus_be <= BE_NONE;
            end
        end
    end

endmodule

// File: tb/tb_lbus_master.sv
// Self-checking bench for lbus_master.
// Instance A uses the default phase lengths and talks to a small
// byte-lane register-file model; a reference word array tracks what the
// register file should hold. Instance B uses long phases (3/5/2) and
// checks back-to-back reads with req_valid held high.
module tb_lbus_master;

    localparam int S_A = 1, T_A = 2, H_A = 1;
    localparam int S_B = 3, T_B = 5, H_B = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rst_b = 1'b1;

    int checks = 0;
    int errors = 0;

    logic        a_req_valid = 1'b0, a_req_ready, a_req_write = 1'b0;
    logic [1:0]  a_req_size = 2'd0;
    logic [23:0] a_req_addr = '0;
    logic [31:0] a_req_wdata = '0;
    logic        a_resp_valid, a_resp_err, a_busy;
    logic [31:0] a_resp_rdata, a_bus_din, a_bus_dout;
    logic [23:0] a_bus_addr;
    logic        a_bus_ws_n, a_bus_rs_n, a_bus_as;
    logic [3:0]  a_bus_be;

    logic        b_req_valid = 1'b0, b_req_ready, b_req_write = 1'b0;
    logic [1:0]  b_req_size = 2'd2;
    logic [23:0] b_req_addr = '0;
    logic [31:0] b_req_wdata = '0;
    logic        b_resp_valid, b_resp_err, b_busy;
    logic [31:0] b_resp_rdata, b_bus_din, b_bus_dout;
    logic [23:0] b_bus_addr;
    logic        b_bus_ws_n, b_bus_rs_n, b_bus_as;
    logic [3:0]  b_bus_be;

    logic [31:0] mem_a [64];
    logic [31:0] ref_mem [64];

    always #5 clk = ~clk;

    lbus_master #(.ADDR_W(24), .DATA_W(32), .SETUP_CYC(S_A), .STROBE_CYC(T_A), .HOLD_CYC(H_A)) dut_a (
        .clk(clk), .rst(rst),
        .req_valid(a_req_valid), .req_ready(a_req_ready), .req_write(a_req_write),
        .req_size(a_req_size), .req_addr(a_req_addr), .req_wdata(a_req_wdata),
        .resp_valid(a_resp_valid), .resp_rdata(a_resp_rdata), .resp_err(a_resp_err),
        .busy(a_busy), .bus_addr(a_bus_addr), .bus_din(a_bus_din), .bus_dout(a_bus_dout),
        .bus_ws_n(a_bus_ws_n), .bus_rs_n(a_bus_rs_n), .bus_be(a_bus_be), .bus_as(a_bus_as)
    );

    lbus_master #(.ADDR_W(24), .DATA_W(32), .SETUP_CYC(S_B), .STROBE_CYC(T_B), .HOLD_CYC(H_B)) dut_b (
        .clk(clk), .rst(rst_b),
        .req_valid(b_req_valid), .req_ready(b_req_ready), .req_write(b_req_write),
        .req_size(b_req_size), .req_addr(b_req_addr), .req_wdata(b_req_wdata),
        .resp_valid(b_resp_valid), .resp_rdata(b_resp_rdata), .resp_err(b_resp_err),
        .busy(b_busy), .bus_addr(b_bus_addr), .bus_din(b_bus_din), .bus_dout(b_bus_dout),
        .bus_ws_n(b_bus_ws_n), .bus_rs_n(b_bus_rs_n), .bus_be(b_bus_be), .bus_as(b_bus_as)
    );

    function automatic logic [31:0] init_word(input int i);
        return 32'h1000_0000 + 32'(i) * 32'h0103_0507;
    endfunction

    function automatic logic [31:0] b_word(input logic [23:0] a);
        return {8'hB0, a} ^ 32'h005A_C300;
    endfunction

    // Register file seen by instance A: lanes written while the write
    // strobe is low, registered read data loaded while the read strobe is
    // low, contents restored to a known pattern while reset is held.
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 64; i++) mem_a[i] <= init_word(i);
            a_bus_dout <= '0;
        end else begin
            if (!a_bus_ws_n) begin
                for (int l = 0; l < 4; l++)
                    if (!a_bus_be[3-l]) mem_a[a_bus_addr[7:2]][8*l +: 8] <= a_bus_din[8*l +: 8];
            end
            if (!a_bus_rs_n) a_bus_dout <= mem_a[a_bus_addr[7:2]];
        end
    end

    // Read-only register file for instance B, data derived from address.
    always @(posedge clk) begin
        if (!b_bus_rs_n) b_bus_dout <= b_word(b_bus_addr);
    end

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // One complete transaction on instance A, checked against the
    // reference: latency, strobe shape, byte enables, data and response.
    task automatic applyStimulus(input logic wr, input logic [1:0] sz,
                                 input logic [23:0] ad, input logic [31:0] wd);
        int bytes, lat, as_cnt, ws_cnt, rs_cnt, first_strobe, viol, unstable, busy_bad, resp_c;
        logic err, got_resp, rerr;
        logic [3:0] exp_be;
        logic [31:0] exp_din, exp_rdata, rdata, mask;

        bytes = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        err = (sz == 2'd3) || ((int'(ad) % bytes) != 0);
        lat = err ? 1 : S_A + T_A + H_A + 1;
        mask = 32'((64'd1 << (8 * bytes)) - 64'd1);
        exp_din = wd & mask;
        exp_be = 4'hF;
        if (wr) for (int l = 0; l < bytes; l++) exp_be[3-l] = 1'b0;
        exp_rdata = (err || wr) ? 32'd0 : ref_mem[ad[7:2]];

        @(negedge clk);
        for (int n = 0; n < 20 && !a_req_ready; n++) @(negedge clk);
        checkOutput("ready_before_req", {63'd0, a_req_ready}, 64'd1);
        a_req_valid = 1'b1; a_req_write = wr; a_req_size = sz; a_req_addr = ad; a_req_wdata = wd;
        @(posedge clk);
        #1;
        a_req_valid = 1'b0;
        a_req_write = 1'($urandom); a_req_size = 2'($urandom);
        a_req_addr = 24'($urandom); a_req_wdata = $urandom;

        got_resp = 0; resp_c = 0; as_cnt = 0; ws_cnt = 0; rs_cnt = 0; first_strobe = 0;
        viol = 0; unstable = 0; busy_bad = 0; rdata = '0; rerr = 0;
        for (int c = 1; c <= 40 && !got_resp; c++) begin
            @(negedge clk);
            if (a_bus_as) begin
                as_cnt++;
                if (a_bus_be !== exp_be || a_bus_addr !== ad || (wr && a_bus_din !== exp_din)) unstable++;
            end
            if (!a_bus_ws_n) ws_cnt++;
            if (!a_bus_rs_n) rs_cnt++;
            if ((!a_bus_ws_n || !a_bus_rs_n) && first_strobe == 0) first_strobe = c;
            if ((!a_bus_ws_n && !a_bus_rs_n) || ((!a_bus_ws_n || !a_bus_rs_n) && !a_bus_as)) viol++;
            if (a_req_ready || !a_busy) busy_bad++;
            if (a_resp_valid) begin
                got_resp = 1; resp_c = c; rdata = a_resp_rdata; rerr = a_resp_err;
            end
        end
        checkOutput("resp_seen", {63'd0, got_resp}, 64'd1);
        checkOutput("resp_cycle", 64'(resp_c), 64'(lat));
        checkOutput("resp_err", {63'd0, rerr}, {63'd0, err});
        checkOutput("resp_rdata", {32'd0, rdata}, {32'd0, exp_rdata});
        checkOutput("as_cycles", 64'(as_cnt), err ? 64'd0 : 64'(S_A + T_A + H_A));
        checkOutput("ws_cycles", 64'(ws_cnt), (err || !wr) ? 64'd0 : 64'(T_A));
        checkOutput("rs_cycles", 64'(rs_cnt), (err || wr) ? 64'd0 : 64'(T_A));
        checkOutput("strobe_start", 64'(first_strobe), err ? 64'd0 : 64'(S_A + 1));
        checkOutput("strobe_exclusive", 64'(viol), 64'd0);
        checkOutput("bus_be_addr_din", 64'(unstable), 64'd0);
        checkOutput("busy_ready", 64'(busy_bad), 64'd0);
        @(negedge clk);
        checkOutput("resp_pulse_end", {62'd0, a_resp_valid, a_req_ready}, 64'd1);

        if (wr && !err)
            for (int l = 0; l < bytes; l++) ref_mem[ad[7:2]][8*l +: 8] = wd[8*l +: 8];
    endtask

    // Reset asserted while a write strobe is low must drop the bus at once
    // and lose the request without any response.
    task automatic resetMidWrite();
        logic found, saw;
        @(negedge clk);
        a_req_valid = 1'b1; a_req_write = 1'b1; a_req_size = 2'd2;
        a_req_addr = 24'h10; a_req_wdata = 32'h0BAD_F00D;
        @(posedge clk);
        #1 a_req_valid = 1'b0;
        found = 0;
        for (int c = 0; c < 10 && !found; c++) begin
            @(negedge clk);
            if (!a_bus_ws_n) found = 1;
        end
        checkOutput("rst_reach_strobe", {63'd0, found}, 64'd1);
        #2 rst = 1'b1;
        #1;
        checkOutput("rst_async_bus", {59'd0, a_bus_ws_n, a_bus_rs_n, a_bus_as, a_busy, a_req_ready},
                    {59'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1});
        checkOutput("rst_async_be", {60'd0, a_bus_be}, 64'hF);
        saw = 0;
        repeat (3) begin
            @(negedge clk);
            if (a_resp_valid) saw = 1;
        end
        rst = 1'b0;
        for (int i = 0; i < 64; i++) ref_mem[i] = init_word(i);
        @(negedge clk);
        if (a_resp_valid) saw = 1;
        checkOutput("rst_no_resp", {63'd0, saw}, 64'd0);
        checkOutput("rst_ready_after", {63'd0, a_req_ready}, 64'd1);
        applyStimulus(1'b0, 2'd2, 24'h10, 32'd0);
    endtask

    // Instance B: two reads with req_valid held high; each responds 11
    // cycles after its handshake and the second handshake follows the
    // first response after exactly one IDLE cycle.
    task automatic applyStimulusHeld();
        int hs[2], rs[2];
        logic [31:0] rd[2];
        int nhs, nrs, ws_bad;
        logic err_seen;
        logic [23:0] addr1, addr2;
        hs = '{-100, -100}; rs = '{-100, -100}; rd = '{32'd0, 32'd0};
        nhs = 0; nrs = 0; ws_bad = 0; err_seen = 0;
        addr1 = 24'($urandom_range(0, 4095)) << 2;
        addr2 = addr1 ^ 24'h0040_0C;
        @(negedge clk);
        b_req_valid = 1'b1; b_req_write = 1'b0; b_req_size = 2'd2; b_req_addr = addr1;
        for (int n = 0; n < 80 && nrs < 2; n++) begin
            if (nhs == 1 && n > hs[0]) b_req_addr = addr2;
            if (nhs == 2 && n > hs[1]) b_req_valid = 1'b0;
            if (!b_bus_ws_n) ws_bad++;
            if (b_resp_valid && nrs < 2) begin
                rs[nrs] = n; rd[nrs] = b_resp_rdata; err_seen |= b_resp_err; nrs++;
            end
            if (b_req_ready && b_req_valid && nhs < 2) begin
                hs[nhs] = n; nhs++;
            end
            @(negedge clk);
        end
        b_req_valid = 1'b0;
        checkOutput("b_handshakes", 64'(nhs), 64'd2);
        checkOutput("b_responses", 64'(nrs), 64'd2);
        checkOutput("b_lat1", 64'(rs[0] - hs[0]), 64'(S_B + T_B + H_B + 1));
        checkOutput("b_idle_gap", 64'(hs[1] - rs[0]), 64'd1);
        checkOutput("b_lat2", 64'(rs[1] - hs[1]), 64'(S_B + T_B + H_B + 1));
        checkOutput("b_rdata1", {32'd0, rd[0]}, {32'd0, b_word(addr1)});
        checkOutput("b_rdata2", {32'd0, rd[1]}, {32'd0, b_word(addr2)});
        checkOutput("b_no_err_no_ws", {31'd0, err_seen, 32'(ws_bad)}, 64'd0);
    endtask

    // Main sequence: reset values, directed cases, reset abort,
    // randomized traffic on A, then the held-valid run on B.
    initial begin
        for (int i = 0; i < 64; i++) ref_mem[i] = init_word(i);
        repeat (3) @(negedge clk);
        checkOutput("reset_ctrl", {58'd0, a_req_ready, a_busy, a_resp_valid, a_resp_err, a_bus_as, a_bus_ws_n},
                    {58'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1});
        checkOutput("reset_rs_be", {59'd0, a_bus_rs_n, a_bus_be}, {59'd0, 1'b1, 4'hF});
        checkOutput("reset_addr_din", {8'd0, a_bus_addr, a_bus_din}, 64'd0);
        checkOutput("reset_rdata", {32'd0, a_resp_rdata}, 64'd0);
        rst = 1'b0;
        rst_b = 1'b0;

        applyStimulus(1'b1, 2'd2, 24'h000004, 32'hDEADBEEF);
        applyStimulus(1'b0, 2'd2, 24'h000004, 32'h0);
        applyStimulus(1'b1, 2'd1, 24'h000008, 32'h1234ABCD);
        applyStimulus(1'b1, 2'd0, 24'h00000C, 32'h000000FF);
        applyStimulus(1'b0, 2'd2, 24'h000008, 32'h0);
        applyStimulus(1'b0, 2'd2, 24'h000006, 32'h0);
        applyStimulus(1'b0, 2'd3, 24'h000000, 32'h0);
        resetMidWrite();

        for (int t = 0; t < 40; t++)
            applyStimulus(1'($urandom), 2'($urandom), 24'($urandom_range(0, 255)), $urandom);

        applyStimulusHeld();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
